// File: rtl/i2c_config_sequencer.sv
// Walks a codec register table and issues one I2C byte write per entry via the GO/END handshake.
// Auto-runs after reset and on START when idle; NACKed writes retry, exhausted entries abort the run.
module i2c_config_sequencer #(
   parameter logic [7:0] DEV_ADDR   = 8'h34,
   parameter int         LUT_SIZE   = 11,
   parameter int         IDX_W      = 4,
   parameter int         MAX_RETRY  = 3,
   parameter int         GAP_CYCLES = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   output logic [IDX_W-1:0] o_lut_index,
   input  logic [15:0]      i_lut_data,
   output logic [23:0]      o_i2c_data,
   output logic             o_i2c_go,
   input  logic             i_i2c_end,
   input  logic             i_i2c_ack,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [IDX_W-1:0] o_err_index
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

   typedef enum logic [2:0] {
      IDLE, LOAD, ARM, XFER, CHECK, GAP, FIN, FAIL
   } state_t;

   state_t           r_state,     w_state;
   logic             r_pending,   w_pending;
   logic             r_arm_wait,  w_arm_wait;
   logic [RW-1:0]    r_retry,     w_retry;
   logic [GW-1:0]    r_gap,       w_gap;
   logic [IDX_W-1:0] r_index,     w_index;
   logic [23:0]      r_data,      w_data;
   logic             r_go,        w_go;
   logic             r_busy,      w_busy;
   logic             r_done,      w_done;
   logic             r_error,     w_error;
   logic [IDX_W-1:0] r_err_index, w_err_index;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_pending   <= 1'b1;
         r_arm_wait  <= 1'b0;
         r_retry     <= '0;
         r_gap       <= '0;
         r_index     <= '0;
         r_data      <= '0;
         r_go        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_err_index <= '0;
      end else begin
         r_state     <= w_state;
         r_pending   <= w_pending;
         r_arm_wait  <= w_arm_wait;
         r_retry     <= w_retry;
         r_gap       <= w_gap;
         r_index     <= w_index;
         r_data      <= w_data;
         r_go        <= w_go;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_error     <= w_error;
         r_err_index <= w_err_index;
      end
   end

   // GO is computed from the next state so the registered output is high exactly in XFER/CHECK.
   always_comb begin
      w_state     = r_state;
      w_pending   = r_pending;
      w_arm_wait  = r_arm_wait;
      w_retry     = r_retry;
      w_gap       = r_gap;
      w_index     = r_index;
      w_data      = r_data;
      w_go        = 1'b0;
      w_busy      = r_busy;
      w_done      = r_done;
      w_error     = r_error;
      w_err_index = r_err_index;
      case (r_state)
         IDLE: begin
            if (r_pending || i_start) begin
               w_state   = LOAD;
               w_pending = 1'b0;
               w_index   = '0;
               w_retry   = '0;
               w_done    = 1'b0;
               w_error   = 1'b0;
               w_busy    = 1'b1;
            end
         end
         LOAD: begin
            w_data     = {DEV_ADDR, i_lut_data};
            w_arm_wait = 1'b0;
            w_state    = ARM;
         end
         ARM: begin
            // Stay at least two cycles and until END is seen low, so a stale END is never taken as completion.
            w_arm_wait = 1'b1;
            if (r_arm_wait && !i_i2c_end) begin
               w_state = XFER;
               w_go    = 1'b1;
            end
         end
         XFER: begin
            w_go = 1'b1;
            if (i_i2c_end) begin
               w_state = CHECK;
            end
         end
         CHECK: begin
            if (!i_i2c_ack) begin
               w_retry = '0;
               if (r_index == IDX_W'(LUT_SIZE - 1)) begin
                  w_state = FIN;
               end else begin
                  w_index = r_index + IDX_W'(1);
                  w_gap   = '0;
                  w_state = GAP;
               end
            end else if (r_retry != RW'(MAX_RETRY)) begin
               w_retry = r_retry + RW'(1);
               w_gap   = '0;
               w_state = GAP;
            end else begin
               w_err_index = r_index;
               w_state     = FAIL;
            end
         end
         GAP: begin
            if (r_gap == GW'(GAP_CYCLES - 1)) begin
               w_state = LOAD;
            end else begin
               w_gap = r_gap + GW'(1);
            end
         end
         FIN: begin
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_state = IDLE;
         end
         FAIL: begin
            w_error = 1'b1;
            w_busy  = 1'b0;
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign o_lut_index = r_index;
   assign o_i2c_data  = r_data;
   assign o_i2c_go    = r_go;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_error     = r_error;
   assign o_err_index = r_err_index;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: behavioural I2C controller with scripted NACKs, scoreboard of expected words.
module tb_i2c_config_sequencer;

   localparam int IDX_W      = 4;
   localparam int LUT_SIZE   = 3;
   localparam int MAX_RETRY  = 3;
   localparam int GAP_CYCLES = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [IDX_W-1:0] lut_index;
   logic [15:0]      lut_data;
   logic [23:0]      i2c_data;
   logic             go;
   logic             i2c_end = 1'b0;
   logic             i2c_ack = 1'b0;
   logic             busy;
   logic             done;
   logic             error;
   logic [IDX_W-1:0] err_index;

   int n_chk = 0;
   int n_err = 0;

   logic [23:0] exp_q[$];
   logic [23:0] cur_word = '0;
   int txn_cnt    = 0;
   int stable_err = 0;
   int low_cnt    = 0;
   int min_gap    = 100000;
   bit have_low   = 1'b0;
   bit prev_go    = 1'b0;

   bit stale      = 1'b0;
   int nack_entry = -1;
   int nack_left  = 0;
   int cyc        = 0;

   always #5 clk = ~clk;

   i2c_config_sequencer #(
      .DEV_ADDR  (8'h34),
      .LUT_SIZE  (LUT_SIZE),
      .IDX_W     (IDX_W),
      .MAX_RETRY (MAX_RETRY),
      .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_start    (start),
      .o_lut_index(lut_index),
      .i_lut_data (lut_data),
      .o_i2c_data (i2c_data),
      .o_i2c_go   (go),
      .i_i2c_end  (i2c_end),
      .i_i2c_ack  (i2c_ack),
      .o_busy     (busy),
      .o_done     (done),
      .o_error    (error),
      .o_err_index(err_index)
   );

   function automatic logic [15:0] lut_word(input int i);
      case (i)
         0:       return 16'h1A01;
         1:       return 16'h2B02;
         2:       return 16'h3C03;
         default: return 16'hDEAD;
      endcase
   endfunction

   assign lut_data = lut_word(int'(lut_index));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_entry(input int i);
      exp_q.push_back({8'h34, lut_word(i)});
   endtask

   task automatic reset_stats();
      txn_cnt    = 0;
      stable_err = 0;
      have_low   = 1'b0;
      min_gap    = 100000;
   endtask

   task automatic wait_busy(input logic lvl, input string tag);
      int n = 0;
      while (busy !== lvl && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, lvl);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Controller model: END 32 cycles into a GO pulse, cleared when GO drops; stale mode pins END high.
   always @(negedge clk) begin
      if (stale) begin
         i2c_end = 1'b1;
         i2c_ack = 1'b0;
         cyc     = 0;
      end else if (go) begin
         cyc++;
         if (cyc == 32) begin
            i2c_end = 1'b1;
            if (int'(lut_index) == nack_entry && nack_left > 0) begin
               i2c_ack = 1'b1;
               nack_left--;
            end else begin
               i2c_ack = 1'b0;
            end
         end
      end else begin
         i2c_end = 1'b0;
         i2c_ack = 1'b0;
         cyc     = 0;
      end
   end

   // Monitor: each GO rise pops one expected word; tracks data stability and GO-low spacing.
   always @(negedge clk) begin
      if (rst) begin
         prev_go  = 1'b0;
         have_low = 1'b0;
      end else begin
         if (go && !prev_go) begin
            txn_cnt++;
            if (have_low && low_cnt < min_gap) min_gap = low_cnt;
            chk("exp_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               cur_word = exp_q.pop_front();
               chk("i2c_data", i2c_data, cur_word);
            end
         end
         if (go && i2c_data !== cur_word) stable_err++;
         if (go) begin
            low_cnt  = 0;
            have_low = 1'b1;
         end else begin
            low_cnt++;
         end
         prev_go = go;
      end
   end

   initial begin
      bit go_seen;
      int n;
      rst   = 1'b1;
      start = 1'b0;
      stale = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_go", go, 0);
      chk("rst_data", i2c_data, 0);
      chk("rst_index", lut_index, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_err_index", err_index, 0);

      // Auto-start with a stale END held high, then a nominal all-ACK run.
      reset_stats();
      push_entry(0); push_entry(1); push_entry(2);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("busy_after_release", busy, 1);
      go_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (go) go_seen = 1'b1;
      end
      chk("stale_go_low", go_seen, 0);
      chk("stale_busy", busy, 1);
      stale = 1'b0;
      wait_busy(1'b0, "run0_end");
      chk("run0_done", done, 1);
      chk("run0_error", error, 0);
      chk("run0_go", go, 0);
      chk("run0_txn", txn_cnt, 3);
      chk("run0_q_empty", exp_q.size(), 0);
      chk("run0_stable", stable_err, 0);
      chk("run0_min_gap_ge19", min_gap >= 19, 1);

      // START after DONE re-runs; a START while busy is ignored.
      reset_stats();
      push_entry(0); push_entry(1); push_entry(2);
      pulse_start();
      chk("restart_done_clr", done, 0);
      chk("restart_busy", busy, 1);
      chk("restart_index", lut_index, 0);
      n = 0;
      while (!go && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("restart_go_seen", go, 1);
      pulse_start();
      wait_busy(1'b0, "run1_end");
      chk("run1_done", done, 1);
      chk("run1_txn", txn_cnt, 3);
      chk("run1_q_empty", exp_q.size(), 0);
      repeat (100) @(negedge clk);
      chk("busy_start_ignored", busy, 0);
      chk("no_extra_txn", txn_cnt, 3);

      // One NACK on entry 1: resent once with identical data.
      reset_stats();
      nack_entry = 1;
      nack_left  = 1;
      push_entry(0); push_entry(1); push_entry(1); push_entry(2);
      pulse_start();
      wait_busy(1'b0, "run2_end");
      chk("run2_done", done, 1);
      chk("run2_error", error, 0);
      chk("run2_txn", txn_cnt, 4);
      chk("run2_q_empty", exp_q.size(), 0);
      chk("run2_stable", stable_err, 0);
      chk("run2_min_gap_ge19", min_gap >= 19, 1);

      // Persistent NACK on entry 2: four attempts then abort.
      reset_stats();
      nack_entry = 2;
      nack_left  = 99;
      push_entry(0); push_entry(1);
      push_entry(2); push_entry(2); push_entry(2); push_entry(2);
      pulse_start();
      wait_busy(1'b0, "run3_end");
      chk("run3_error", error, 1);
      chk("run3_err_index", err_index, 2);
      chk("run3_done", done, 0);
      chk("run3_go", go, 0);
      chk("run3_txn", txn_cnt, 6);
      chk("run3_q_empty", exp_q.size(), 0);

      // Reset during XFER of entry 1, then a full automatic re-run.
      reset_stats();
      nack_entry = -1;
      nack_left  = 0;
      push_entry(0); push_entry(1);
      push_entry(0); push_entry(1); push_entry(2);
      pulse_start();
      chk("run4_error_clr", error, 0);
      n = 0;
      while (!(go && lut_index == 4'd1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("run4_in_xfer1", go && lut_index == 4'd1, 1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_go", go, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_data", i2c_data, 0);
      chk("midrst_index", lut_index, 0);
      chk("midrst_err_index", err_index, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_busy(1'b1, "run4_restart");
      wait_busy(1'b0, "run4_end");
      chk("run4_done", done, 1);
      chk("run4_txn", txn_cnt, 5);
      chk("run4_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
